// File: rtl/mem_stream_reader.sv
// Burst read sequencer for a 1-cycle-latency BRAM port. It issues COUNT
// consecutive reads from a base address and wraps the address modulo DEPTH.
// A 2-entry skid FIFO absorbs the read latency. The words leave as a
// valid/ready stream with a last marker.
module mem_stream_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                     clkB,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic [LEN_W-1:0]         count,
  output logic                     busy,
  output logic                     done,
  output logic                     enB,
  output logic [$clog2(DEPTH)-1:0] addrB,
  input  logic [WIDTH-1:0]         doutB,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    addr, addr_nxt;
  logic [LEN_W-1:0] issue_left, issue_left_nxt;
  logic [LEN_W-1:0] sent_left, sent_left_nxt;
  logic             done_nxt;

  logic             inflight;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;
  logic             pop;
  logic             credit;

  // Stream side and read-issue decisions, all derived from registered state
  always_comb begin
    m_valid = (fifo_cnt != 2'd0);
    pop     = m_valid && m_ready;
    // Words already held plus the word in flight, less the word leaving, must leave room for one more
    credit  = (3'(fifo_cnt) + 3'(inflight) - 3'(pop)) < 3'd2;
    enB     = (state == RUN) && credit;
    addrB   = enB ? addr : '0;
    m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    m_last  = m_valid && (sent_left == LEN_W'(1));
    busy    = (state != IDLE);
  end

  // Next-state logic: burst bookkeeping and the completion pulse
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    issue_left_nxt = issue_left;
    sent_left_nxt  = sent_left;
    done_nxt       = 1'b0;

    if (pop) begin
      sent_left_nxt = sent_left - LEN_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt      = RUN;
            addr_nxt       = base_addr;
            issue_left_nxt = count;
            sent_left_nxt  = count;
          end
        end
      end
      RUN: begin
        if (enB) begin
          addr_nxt       = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
          issue_left_nxt = issue_left - LEN_W'(1);
          if (issue_left == LEN_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (sent_left == LEN_W'(1))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clkB) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      issue_left <= '0;
      sent_left  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      issue_left <= issue_left_nxt;
      sent_left  <= sent_left_nxt;
      done       <= done_nxt;
    end
  end

  // Skid FIFO pointers and occupancy; a read issued last cycle always lands
  always_ff @(posedge clkB) begin
    if (rst) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      inflight <= enB;
      if (inflight) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Skid FIFO storage; data path only, so it has no reset
  always_ff @(posedge clkB) begin
    if (inflight) begin
      fifo_mem[wr_ptr] <= doutB;
    end
  end

endmodule
